// File: rtl/alu_arbiter_if.sv
// Purpose : bundles the two requester channels, the shared-ALU drive/return
//           path and the per-requester response channel of alu_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: n/a. Per requester: reqN_valid/reqN_ready for issue and
//           rspN_valid/rspN_ready for the result.
// Ports (slave = arbiter side, master = requesters + ALU side):
//   req0_*/req1_*  : valid, op1, op2, field in; ready out
//   alu_*          : op1, op2, field out; result in (combinational ALU)
//   rsp*_valid, rsp_result, busy out; rsp*_ready in
interface alu_arbiter_if;
    // requester 0
    logic        req0_valid;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic [3:0]  req0_field;
    logic        req0_ready;
    // requester 1
    logic        req1_valid;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic [3:0]  req1_field;
    logic        req1_ready;
    // shared ALU
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_field;
    logic [31:0] alu_result;
    // response channel
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic        busy;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_field,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2, req1_field,
        output req1_ready,
        output alu_op1, alu_op2, alu_field,
        input  alu_result,
        output rsp0_valid, rsp1_valid, rsp_result,
        input  rsp0_ready, rsp1_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_field,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2, req1_field,
        input  req1_ready,
        input  alu_op1, alu_op2, alu_field,
        output alu_result,
        input  rsp0_valid, rsp1_valid, rsp_result,
        output rsp0_ready, rsp1_ready,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose : shares one combinational ALU between two requesters with
//           alternating priority and holds the result until it is consumed.
// Latency : 1 cycle from acceptance (reqN_ready) to rspN_valid.
// Backpressure: a held response (rspN_ready low) blocks all new grants.
// Ports:
//   clk, rst  : single clock, asynchronous active-high reset
//   bus       : alu_arbiter_if.slave (requests, ALU drive/return, responses)
// Parameter:
//   INIT_PRIO : requester that wins a tie after reset (0 or 1)
module alu_arbiter #(
    parameter logic INIT_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP0 = 2'd1,
        RESP1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;        // requester that wins when both are valid
    logic        w_prio_nxt;
    logic [31:0] r_rsp_result;
    logic        w_grant0;
    logic        w_grant1;

    // ------------------------------------------------------------------
    // Grant decision. Grants only happen in IDLE; a pending response holds
    // off every new request, which is what makes the issue interval two
    // cycles. Reset gates the grant so readies and alu_* read zero while
    // rst is high, regardless of what the requesters present.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst && (r_state == IDLE)) begin
            if (bus.req0_valid && (!bus.req1_valid || (r_prio == 1'b0))) begin
                w_grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and priority update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            IDLE: begin
                if (w_grant0) begin
                    w_state_nxt = RESP0;
                    w_prio_nxt  = 1'b1;
                end else if (w_grant1) begin
                    w_state_nxt = RESP1;
                    w_prio_nxt  = 1'b0;
                end
            end
            // Only the owner's ready retires the response; the other
            // requester's rsp ready is deliberately not looked at.
            RESP0: begin
                if (bus.rsp0_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            RESP1: begin
                if (bus.rsp1_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and ALU drive. Operands are passed through untouched,
    // including undefined field codes; idle cycles drive zeros so the
    // ALU inputs do not toggle with unaccepted requests.
    // ------------------------------------------------------------------
    always_comb begin
        bus.req0_ready = w_grant0;
        bus.req1_ready = w_grant1;
        bus.alu_op1    = 32'd0;
        bus.alu_op2    = 32'd0;
        bus.alu_field  = 4'd0;
        if (w_grant0) begin
            bus.alu_op1   = bus.req0_op1;
            bus.alu_op2   = bus.req0_op2;
            bus.alu_field = bus.req0_field;
        end else if (w_grant1) begin
            bus.alu_op1   = bus.req1_op1;
            bus.alu_op2   = bus.req1_op2;
            bus.alu_field = bus.req1_field;
        end
    end

    // ------------------------------------------------------------------
    // State, priority and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= INIT_PRIO;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // The result is captured only on the granting edge, so it stays stable
    // for as long as the response is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_result <= 32'd0;
        end else if (w_grant0 || w_grant1) begin
            r_rsp_result <= bus.alu_result;
        end
    end

    // Response flags decode straight from state, so an asynchronous reset
    // clears them the moment rst rises.
    assign bus.rsp0_valid = (r_state == RESP0);
    assign bus.rsp1_valid = (r_state == RESP1);
    assign bus.busy       = (r_state != IDLE);
    assign bus.rsp_result = r_rsp_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : directed + randomized bench for alu_arbiter with a transaction
//           level model (who owns the pending result, what it is, who wins
//           the next tie) and a behavioural RV32 ALU on the alu_* port.
module tb_alu_arbiter;

    localparam logic INIT_P = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter #(.INIT_PRIO(INIT_P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU: {funct7[5], funct3} decode of the RV32I register ops.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
        case (f)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'd0, ($signed(a) < $signed(b))};
            4'b0011: return {31'd0, (a < b)};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_op1, bus.alu_op2, bus.alu_field);

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level model
    int          m_pend;   // -1 none, else requester whose result is held
    logic [31:0] m_res;    // value the response register should show
    int          m_prio;   // requester that wins a tie
    int          m_grant;  // grant expected in the current cycle (-1 none)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = -1;
        m_res   = 32'd0;
        m_prio  = int'(INIT_P);
        m_grant = -1;
    endtask

    task automatic check_all();
        int g;
        logic [31:0] e1, e2;
        logic [3:0]  ef;
        if (rst || m_pend >= 0)                  g = -1;
        else if (bus.req0_valid && bus.req1_valid) g = m_prio;
        else if (bus.req0_valid)                 g = 0;
        else if (bus.req1_valid)                 g = 1;
        else                                     g = -1;
        m_grant = g;
        e1 = (g == 0) ? bus.req0_op1   : (g == 1) ? bus.req1_op1   : 32'd0;
        e2 = (g == 0) ? bus.req0_op2   : (g == 1) ? bus.req1_op2   : 32'd0;
        ef = (g == 0) ? bus.req0_field : (g == 1) ? bus.req1_field : 4'd0;
        chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
        chk("alu_op1",    bus.alu_op1, e1);
        chk("alu_op2",    bus.alu_op2, e2);
        chk("alu_field",  32'(bus.alu_field), 32'(ef));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_pend == 0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_pend == 1));
        chk("busy",       32'(bus.busy), 32'(m_pend >= 0));
        chk("rsp_result", bus.rsp_result, m_res);
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic update_model();
        if (m_grant == 0) begin
            m_res  = alu_fn(bus.req0_op1, bus.req0_op2, bus.req0_field);
            m_pend = 0;
            m_prio = 1;
        end else if (m_grant == 1) begin
            m_res  = alu_fn(bus.req1_op1, bus.req1_op2, bus.req1_field);
            m_pend = 1;
            m_prio = 0;
        end else if (m_pend == 0 && bus.rsp0_ready) begin
            m_pend = -1;
        end else if (m_pend == 1 && bus.rsp1_ready) begin
            m_pend = -1;
        end
    endtask

    // Inputs are driven at posedge+1; checks land at posedge+4.
    task automatic pre();
        #3;
        check_all();
    endtask

    task automatic post();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_field = f;
        end else begin
            bus.req1_valid = v; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_field = f;
        end
    endtask

    initial begin
        model_reset();
        set_req(0, 1'b1, 32'h11, 32'h22, 4'h0);
        set_req(1, 1'b1, 32'h33, 32'h44, 4'h7);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state with both requests presented: nothing may leak out.
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Single request: ADD 5,3
        set_req(0, 1'b1, 32'd5, 32'd3, 4'b0000);
        pre();
        chk("d_single_ready", 32'(bus.req0_ready), 32'd1);
        chk("d_single_op1", bus.alu_op1, 32'd5);
        chk("d_single_op2", bus.alu_op2, 32'd3);
        post();
        chk("d_single_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("d_single_result", bus.rsp_result, 32'd8);
        bus.req0_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        step();

        // Contention: both valid every cycle, responses consumed at once.
        do_reset();
        set_req(0, 1'b1, 32'd10, 32'd4, 4'b1000);
        set_req(1, 1'b1, 32'hF0, 32'h3C, 4'b0111);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pre();
            chk("d_cont_r0", 32'(bus.req0_ready), 32'((i % 2 == 0) && ((i / 2) % 2 == 0)));
            chk("d_cont_r1", 32'(bus.req1_ready), 32'((i % 2 == 0) && ((i / 2) % 2 == 1)));
            post();
            if (i % 2 == 0)
                chk("d_cont_result", bus.rsp_result, ((i / 2) % 2 == 0) ? 32'd6 : 32'h30);
        end

        // Backpressure: req1 XOR held for 5 cycles while req0 waits.
        bus.req0_valid = 1'b0;
        set_req(1, 1'b1, 32'hFF, 32'h0F, 4'b0100);
        bus.rsp1_ready = 1'b0;
        step();
        bus.req1_valid = 1'b0;
        set_req(0, 1'b1, 32'd1, 32'd2, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            pre();
            chk("d_bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
            chk("d_bp_result", bus.rsp_result, 32'hF0);
            chk("d_bp_req0_ready", 32'(bus.req0_ready), 32'd0);
            chk("d_bp_busy", 32'(bus.busy), 32'd1);
            post();
        end
        bus.req0_valid = 1'b0;
        bus.rsp1_ready = 1'b1;
        step();

        // Wrong ready: rsp1_ready must not retire a RESP0 result.
        set_req(0, 1'b1, 32'd7, 32'd9, 4'b0000);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pre();
            chk("d_wrong_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
            chk("d_wrong_result", bus.rsp_result, 32'd16);
            post();
        end
        bus.rsp0_ready = 1'b1;
        step();

        // Mid-operation reset while RESP1 is pending.
        set_req(1, 1'b1, 32'd100, 32'd1, 4'b1000);
        bus.rsp1_ready = 1'b0;
        step();
        bus.req1_valid = 1'b0;
        pre();
        chk("d_rst_pre_rsp1", 32'(bus.rsp1_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("d_rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("d_rst_busy", 32'(bus.busy), 32'd0);
        chk("d_rst_result", bus.rsp_result, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(0, 1'b1, 32'd2, 32'd2, 4'b0000);
        set_req(1, 1'b1, 32'd3, 32'd3, 4'b0000);
        pre();
        chk("d_rst_first_r0", 32'(bus.req0_ready), 32'd1);
        chk("d_rst_first_r1", 32'(bus.req1_ready), 32'd0);
        post();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        step();

        // Idle: 10 cycles with no valids and garbage operands on the buses.
        for (int i = 0; i < 10; i++) begin
            set_req(0, 1'b0, $urandom, $urandom, 4'($urandom));
            set_req(1, 1'b0, $urandom, $urandom, 4'($urandom));
            step();
        end
        set_req(0, 1'b1, 32'd4, 32'd4, 4'b0110);
        set_req(1, 1'b1, 32'd5, 32'd5, 4'b0110);
        pre();
        chk("d_idle_prio_r1", 32'(bus.req1_ready), 32'd1);
        post();
        bus.rsp1_ready = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            set_req(0, ($urandom_range(0, 2) != 0), $urandom, $urandom, 4'($urandom));
            set_req(1, ($urandom_range(0, 2) != 0), $urandom, $urandom, 4'($urandom));
            bus.rsp0_ready = ($urandom_range(0, 4) > 1);
            bus.rsp1_ready = ($urandom_range(0, 4) > 1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter INIT_PRIO, default 0: the requester that holds priority after reset (0 or 1).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port req0_op1, req0_op2  input  32 each  requester 0 operands.
REQ-006 Port req0_field  input  4  requester 0 ALU field {funct7[5], funct3}.
REQ-007 Port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 Port req1_valid, req1_op1, req1_op2, req1_field, req1_ready: same as REQ-004..REQ-007 for requester 1.
REQ-009 Port alu_op1, alu_op2  output  32 each  operands driven to the shared ALU.
REQ-010 Port alu_field  output  4  field driven to the shared ALU.
REQ-011 Port alu_result  input  32  combinational ALU result for the current alu_* outputs.
REQ-012 Port rsp0_valid  output  1  result for requester 0 is held on rsp_result.
REQ-013 Port rsp1_valid  output  1  result for requester 1 is held on rsp_result.
REQ-014 Port rsp_result  output  32  registered ALU result.
REQ-015 Port rsp0_ready, rsp1_ready  input  1 each  requester consumes its result.
REQ-016 Port busy  output  1  high whenever a response is pending.

Function
REQ-017 The block SHALL implement states IDLE, RESP0 and RESP1.
REQ-018 In IDLE with exactly one reqN_valid high, it SHALL grant requester N.
REQ-019 In IDLE with both valid, it SHALL grant the requester holding priority.
REQ-020 On any grant to N, priority SHALL pass to the other requester at the clock edge.
REQ-021 Priority SHALL be unchanged in cycles without a grant.
REQ-022 In a granting cycle, reqN_ready SHALL be 1 combinationally, the other ready SHALL be 0, and alu_* SHALL carry requester N's op1, op2 and field unmodified.
REQ-023 When no grant occurs, including any cycle in RESP0 or RESP1, both readies SHALL be 0 and alu_op1, alu_op2 and alu_field SHALL be 0.
REQ-024 At the edge ending a granting cycle, alu_result SHALL be captured into rsp_result and the state SHALL go to RESPN.
REQ-025 Latency SHALL be 1: rspN_valid is high in the cycle after acceptance.
REQ-026 In RESPN, rspN_valid SHALL be 1 and rsp_result SHALL be held stable until rspN_ready is sampled high.
REQ-027 The other rsp valid SHALL be 0 in RESPN.
REQ-028 RESPN with rspN_ready high SHALL return to IDLE.
REQ-029 No new grant SHALL occur in the RESP cycle, so the minimum issue interval is 2 cycles.
REQ-030 rspM_ready for the non-pending requester SHALL be ignored.
REQ-031 reqN_valid deasserted before a grant SHALL be dropped without side effects.
REQ-032 A request that stays valid while the other requester is being serviced SHALL be granted no later than the next IDLE cycle (starvation-free).
REQ-033 Field codes SHALL pass through unchecked; undefined codes yield whatever alu_result presents.
REQ-034 busy SHALL equal (state != IDLE).

Reset
REQ-035 While rst is high, independent of clk: state=IDLE, priority=INIT_PRIO, rsp0_valid=rsp1_valid=0, rsp_result=0, busy=0, readies=0, alu_*=0.
REQ-036 Reset during RESP0/RESP1 SHALL discard the pending result.
REQ-037 The first grant after reset deassertion SHALL follow INIT_PRIO.

Verification
REQ-038 Single request: INIT_PRIO=0; req0 op1=5, op2=3, field=0000 with ALU model -> req0_ready=1 in that cycle, alu_* = 5/3/0000, next cycle rsp0_valid=1 and rsp_result=8.
REQ-039 Contention: both valid every cycle (req0 SUB 10,4; req1 AND 0xF0,0x3C), rsp readies tied high -> grants 0,1,0,1 on alternating cycles; results 6 and 0x30 alternate.
REQ-040 Backpressure: rsp1_ready low for 5 cycles after a req1 XOR 0xFF,0x0F -> rsp1_valid and rsp_result=0xF0 held 5 cycles; req0_ready stays 0; busy=1.
REQ-041 Wrong ready: in RESP0, rsp1_ready=1 and rsp0_ready=0 -> state stays RESP0.
REQ-042 Mid-operation reset: rst asserted asynchronously in RESP1 -> rsp1_valid, busy and rsp_result go to 0 immediately; the next grant goes to INIT_PRIO.
REQ-043 Idle: no valids for 10 cycles -> alu_* = 0, readies 0, priority unchanged.
